// File: rtl/mem_access_unit_pkg.sv
// Shared LC-3b types for the MEM-stage access unit: opcode, byte mask,
// and the access-sequencer state encoding.
package mem_access_unit_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IND_READ = 2'd1,
        ACCESS   = 2'd2,
        DONE     = 2'd3
    } mem_access_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-cache bus between the MEM-stage access unit (master) and the cache (slave).
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   dmem_address;
    logic                    dmem_read;
    logic                    dmem_write;
    logic [DATA_WIDTH/8-1:0] dmem_byte_enable;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic [DATA_WIDTH-1:0]   dmem_rdata;
    logic                    dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_access_unit_stall_counter.sv
// Saturating count of pipeline stall cycles; only built with MEM_ACCESS_PERF_EN.
`ifdef MEM_ACCESS_PERF_EN
module mem_access_unit_stall_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (stall && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end
endmodule
`endif

// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage responder: sequences single and LDI/STI data-cache accesses and
// stalls the pipeline until done. MEM_ACCESS_PERF_EN adds a stall_count output.
//
// state    | meaning
// IDLE     | waiting for a request; stall follows the request combinationally
// IND_READ | fetching the LDI/STI pointer word
// ACCESS   | final data access using captured fields (or the fetched pointer)
// DONE     | one-cycle completion pulse, pipeline released
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  lc3b_opcode              opcode,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic                    indirect_enable,
    input  logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic                    is_nop,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   store_data,
    mem_access_unit_if.master       dmem,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    mem_stall,
    output logic                    mem_done
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0]             stall_count
`endif
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    mem_access_state_t     state, state_next;
    lc3b_opcode            cap_opcode;
    logic [ADDR_WIDTH-1:0] cap_address;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [BE_WIDTH-1:0]   cap_be;
    logic                  cap_write;
    logic                  cap_indirect;
    logic [ADDR_WIDTH-1:0] pointer;
    logic [DATA_WIDTH-1:0] load_q;

    logic                  request;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] access_addr;
    logic                  access_write;
    logic                  read_strobe;
    logic                  write_strobe;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [BE_WIDTH-1:0]   bus_be;
    logic [DATA_WIDTH-1:0] bus_wdata;

    assign request   = req_valid & ~is_nop & (mem_read | mem_write);
    assign base_addr = cap_indirect ? pointer : cap_address;
    assign access_addr = (cap_be == '1) ? {base_addr[ADDR_WIDTH-1:1], 1'b0} : base_addr;
    // STI decodes as a read in the control word; the write direction is recovered here.
    assign access_write = cap_indirect ? (cap_opcode == op_sti) : cap_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cap_opcode   <= op_br;
            cap_address  <= '0;
            cap_wdata    <= '0;
            cap_be       <= '0;
            cap_write    <= 1'b0;
            cap_indirect <= 1'b0;
            pointer      <= '0;
            load_q       <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && request) begin
                cap_opcode   <= opcode;
                cap_address  <= address;
                cap_wdata    <= store_data;
                cap_be       <= mem_byte_enable;
                cap_write    <= mem_write;
                cap_indirect <= indirect_enable;
            end
            if ((state == IND_READ) && dmem.dmem_resp) begin
                pointer <= dmem.dmem_rdata[ADDR_WIDTH-1:0];
            end
            if (read_strobe && dmem.dmem_resp) begin
                load_q <= dmem.dmem_rdata;
            end
        end
    end

    always_comb begin
        state_next   = state;
        mem_stall    = 1'b0;
        mem_done     = 1'b0;
        read_strobe  = 1'b0;
        write_strobe = 1'b0;
        bus_addr     = '0;
        bus_be       = '0;
        bus_wdata    = '0;
        case (state)
            IDLE: begin
                mem_stall = request;
                if (request) begin
                    state_next = indirect_enable ? IND_READ : ACCESS;
                end
            end
            IND_READ: begin
                mem_stall   = 1'b1;
                read_strobe = 1'b1;
                bus_addr    = {cap_address[ADDR_WIDTH-1:1], 1'b0};
                bus_be      = '1;
                if (dmem.dmem_resp) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_stall    = 1'b1;
                read_strobe  = ~access_write;
                write_strobe = access_write;
                bus_addr     = access_addr;
                bus_be       = cap_be;
                bus_wdata    = cap_wdata;
                if (dmem.dmem_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                mem_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dmem.dmem_address     = bus_addr;
    assign dmem.dmem_read        = read_strobe;
    assign dmem.dmem_write       = write_strobe;
    assign dmem.dmem_byte_enable = bus_be;
    assign dmem.dmem_wdata       = bus_wdata;
    assign load_data             = load_q;

`ifdef MEM_ACCESS_PERF_EN
    mem_access_unit_stall_counter u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .stall (mem_stall),
        .count (stall_count)
    );
`else
    // default build carries no profiling hardware
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a cache responder checks each access against
// the model's queue, and a completion monitor checks load_data and stall length.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    lc3b_opcode opcode = op_br;
    logic       mem_read = 1'b0;
    logic       mem_write = 1'b0;
    logic       indirect_enable = 1'b0;
    logic [1:0] mem_byte_enable = 2'b00;
    logic       is_nop = 1'b0;
    logic [15:0] address = 16'h0;
    logic [15:0] store_data = 16'h0;
    logic [15:0] load_data;
    logic        mem_stall;
    logic        mem_done;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] stall_count;
`endif

    logic        resp_drv = 1'b0;
    logic        stray_resp = 1'b0;
    logic [15:0] rdata_drv = 16'h0;

    mem_access_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dmem_bus ();
    assign dmem_bus.dmem_resp  = resp_drv | stray_resp;
    assign dmem_bus.dmem_rdata = rdata_drv;

    mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .opcode          (opcode),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .indirect_enable (indirect_enable),
        .mem_byte_enable (mem_byte_enable),
        .is_nop          (is_nop),
        .address         (address),
        .store_data      (store_data),
        .dmem            (dmem_bus),
        .load_data       (load_data),
        .mem_stall       (mem_stall),
        .mem_done        (mem_done)
`ifdef MEM_ACCESS_PERF_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [15:0] addr; logic [1:0] be; logic [15:0] wdata; } acc_t;
    typedef struct { int lat; logic [15:0] data; } rsp_t;
    typedef struct { logic [15:0] load; int stalls; } done_t;

    acc_t  exp_acc[$];
    rsp_t  rsp_q[$];
    done_t exp_done[$];

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_load = 16'h0;
    int stall_run = 0;
    int total_stall = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: computes the expected cache accesses, final load word and stall
    // length of one transaction, then issues it and waits for completion.
    task automatic issue(input lc3b_opcode op, input logic rd, input logic wr, input logic ind,
                         input logic [1:0] be, input logic [15:0] addr, input logic [15:0] sd,
                         input logic [15:0] d1, input logic [15:0] d2, input int n1, input int n2);
        logic [15:0] base;
        logic        is_wr;
        logic        ok;
        if (ind) begin
            exp_acc.push_back('{1'b0, addr & 16'hFFFE, 2'b11, 16'h0});
            rsp_q.push_back('{n1, d1});
            exp_load = d1;
            base  = d1;
            is_wr = (op == op_sti);
        end else begin
            base  = addr;
            is_wr = wr;
        end
        exp_acc.push_back('{is_wr, (be == 2'b11) ? (base & 16'hFFFE) : base, be, sd});
        rsp_q.push_back('{n2, d2});
        if (!is_wr) exp_load = d2;
        exp_done.push_back('{exp_load, ind ? (n1 + n2 + 3) : (n2 + 2)});

        @(posedge clk); #1;
        req_valid = 1'b1; opcode = op; mem_read = rd; mem_write = wr;
        indirect_enable = ind; mem_byte_enable = be; is_nop = 1'b0;
        address = addr; store_data = sd;
        @(posedge clk); #1;
        req_valid       = 1'b0;
        opcode          = lc3b_opcode'(4'($urandom_range(0, 15)));
        mem_read        = 1'($urandom_range(0, 1));
        mem_write       = 1'($urandom_range(0, 1));
        indirect_enable = 1'($urandom_range(0, 1));
        mem_byte_enable = 2'($urandom_range(0, 3));
        address         = 16'($urandom);
        store_data      = 16'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_done) begin ok = 1'b1; break; end
        end
        chk("done_timeout", {31'd0, ok}, 32'd1);
    endtask

    // Cache responder: checks each strobed access, holds it for its latency, then pulses resp.
    acc_t e;
    rsp_t r;
    logic aborted;
    initial begin
        forever begin
            @(negedge clk);
            while (!reset && (dmem_bus.dmem_read || dmem_bus.dmem_write)) begin
                aborted = 1'b0;
                if (exp_acc.size() == 0) begin
                    chk("unexpected_access", 32'(exp_acc.size()), 32'd1);
                end else begin
                    e = exp_acc.pop_front();
                    chk("acc_write", {31'd0, dmem_bus.dmem_write}, {31'd0, e.wr});
                    chk("acc_read", {31'd0, dmem_bus.dmem_read}, {31'd0, ~e.wr});
                    chk("acc_addr", {16'd0, dmem_bus.dmem_address}, {16'd0, e.addr});
                    chk("acc_be", {30'd0, dmem_bus.dmem_byte_enable}, {30'd0, e.be});
                    if (e.wr) chk("acc_wdata", {16'd0, dmem_bus.dmem_wdata}, {16'd0, e.wdata});
                end
                r = (rsp_q.size() != 0) ? rsp_q.pop_front() : '{0, 16'h0};
                for (int i = 0; i < r.lat; i++) begin
                    @(negedge clk);
                    if (reset) begin aborted = 1'b1; break; end
                    chk("strobe_held", {31'd0, dmem_bus.dmem_read | dmem_bus.dmem_write}, 32'd1);
                end
                if (!aborted) begin
                    rdata_drv = r.data;
                    resp_drv  = 1'b1;
                    @(negedge clk);
                    resp_drv  = 1'b0;
                    rdata_drv = 16'($urandom);
                end
            end
        end
    end

    // Completion monitor.
    done_t d;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_run = 0; total_stall = 0; prev_done = 1'b0;
            end else begin
                if (mem_stall) begin stall_run++; total_stall++; end
                if (mem_done) begin
                    chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
                    chk("stall_in_done", {31'd0, mem_stall}, 32'd0);
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", 32'(exp_done.size()), 32'd1);
                    end else begin
                        d = exp_done.pop_front();
                        chk("load_data", {16'd0, load_data}, {16'd0, d.load});
                        chk("stall_cycles", 32'(stall_run), 32'(d.stalls));
                    end
                    stall_run = 0;
                end
                prev_done = mem_done;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_read"}, {31'd0, dmem_bus.dmem_read}, 32'd0);
        chk({tag, "_write"}, {31'd0, dmem_bus.dmem_write}, 32'd0);
        chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
        chk({tag, "_done"}, {31'd0, mem_done}, 32'd0);
    endtask

    initial begin
        logic       ind, wr, rd;
        logic [1:0] be;
        lc3b_opcode op;

        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_addr", {16'd0, dmem_bus.dmem_address}, 32'd0);
        chk("reset_load", {16'd0, load_data}, 32'd0);
        reset = 1'b0;

        issue(op_ldr, 1'b1, 1'b0, 1'b0, 2'b11, 16'h1235, 16'h0000, 16'h0000, 16'hBEEF, 0, 2);
        issue(op_stb, 1'b0, 1'b1, 1'b0, 2'b01, 16'h2001, 16'h00AA, 16'h0000, 16'h7777, 0, 1);
        issue(op_ldi, 1'b1, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h0000, 16'h4000, 16'h5555, 1, 2);
        issue(op_sti, 1'b1, 1'b0, 1'b1, 2'b11, 16'h3003, 16'h1234, 16'h6000, 16'h9999, 2, 0);

        // bubble with a read request plus a stray response while idle
        @(posedge clk); #1;
        req_valid = 1'b1; is_nop = 1'b1; mem_read = 1'b1; mem_write = 1'b0; indirect_enable = 1'b0;
        stray_resp = 1'b1; rdata_drv = 16'hDEAD;
        @(negedge clk);
        chk_quiet("nop");
        @(posedge clk); #1;
        stray_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_quiet("nop");
        end
        chk("nop_load", {16'd0, load_data}, {16'd0, exp_load});
        @(posedge clk); #1;
        req_valid = 1'b0; is_nop = 1'b0;

        for (int k = 0; k < 40; k++) begin
            ind = ($urandom_range(0, 3) == 0);
            if (ind) begin
                op = $urandom_range(0, 1) ? op_sti : op_ldi;
                rd = 1'b1; wr = 1'b0; be = 2'b11;
            end else begin
                wr = 1'($urandom_range(0, 1));
                rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
                be = 2'($urandom_range(1, 3));
                op = wr ? ((be == 2'b11) ? op_str : op_stb) : ((be == 2'b11) ? op_ldr : op_ldb);
            end
            issue(op, rd, wr, ind, be, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef MEM_ACCESS_PERF_EN
        @(negedge clk);
        chk("stall_count", stall_count, 32'(total_stall));
`endif

        // reset while fetching an LDI pointer
        exp_acc.push_back('{1'b0, 16'h7A10, 2'b11, 16'h0});
        rsp_q.push_back('{6, 16'h1111});
        @(posedge clk); #1;
        req_valid = 1'b1; opcode = op_ldi; mem_read = 1'b1; mem_write = 1'b0;
        indirect_enable = 1'b1; mem_byte_enable = 2'b11; address = 16'h7A11;
        @(posedge clk); #1;
        req_valid = 1'b0; indirect_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("ind_read_active", {31'd0, dmem_bus.dmem_read}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_quiet("abort");
        chk("abort_addr", {16'd0, dmem_bus.dmem_address}, 32'd0);
        chk("abort_load", {16'd0, load_data}, 32'd0);
`ifdef MEM_ACCESS_PERF_EN
        chk("abort_stall_count", stall_count, 32'd0);
`endif
        exp_load = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(op_ldr, 1'b1, 1'b0, 1'b0, 2'b11, 16'h1235, 16'h0000, 16'h0000, 16'hCAFE, 0, 1);
        issue(op_ldb, 1'b1, 1'b0, 1'b0, 2'b10, 16'h0F0F, 16'h0000, 16'h0000, 16'h8081, 0, 0);

        repeat (3) @(negedge clk);
        chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
`ifdef MEM_ACCESS_PERF_EN
        chk("stall_count_final", stall_count, 32'(total_stall));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
